// File: rtl/cal_pkg.sv
// Shared types and constants for the shift-add calculation unit.
package cal_pkg;

  localparam int unsigned CAL_WIDTH = 16;
  localparam int unsigned CAL_IDX_W = 8;

  // Result carries the full product plus IDX_W bits of headroom for the running sum.
  function automatic int unsigned result_w(input int unsigned width, input int unsigned idx_w);
    return 2 * width + idx_w;
  endfunction

  localparam int unsigned CAL_RES_W = 2 * CAL_WIDTH + CAL_IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_BUSY = 2'd2,
    ST_DONE = 2'd3
  } cal_state_e;

endpackage

// File: rtl/cal_if.sv
// Controller <-> calculation unit handshake bundle.
interface cal_if
  import cal_pkg::*;
#(
  parameter int unsigned WIDTH = CAL_WIDTH,
  parameter int unsigned IDX_W = CAL_IDX_W
);
  localparam int unsigned RES_W = result_w(WIDTH, IDX_W);

  logic                 write_reg;
  logic [IDX_W-1:0]     index;
  logic [2*WIDTH-1:0]   data_in;
  logic                 cal_finish;
  logic [RES_W-1:0]     result;
  logic [IDX_W-1:0]     result_index;
  logic                 busy;

  modport master (
    output write_reg, index, data_in,
    input  cal_finish, result, result_index, busy
  );

  modport slave (
    input  write_reg, index, data_in,
    output cal_finish, result, result_index, busy
  );

endinterface

// File: rtl/cal_shift_add.sv
// Sequential shift-add multiplier core: operand registers, partial product, bit counter.
module cal_shift_add
  import cal_pkg::*;
#(
  parameter int unsigned WIDTH = CAL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 clear,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 last_c,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PP_W  = 2 * WIDTH;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [PP_W-1:0]  pp_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      pp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (load) begin
        a_q <= a_in;
        b_q <= b_in;
      end
      if (clear) begin
        pp_q  <= '0;
        cnt_q <= '0;
      end
      // One multiplier bit per cycle: B is consumed LSB first.
      if (step) begin
        if (b_q[0]) pp_q <= pp_q + (PP_W'(a_q) << cnt_q);
        b_q   <= b_q >> 1;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign last_c  = (cnt_q == CNT_W'(WIDTH - 1));
  assign product = pp_q;

endmodule

// File: rtl/cal_unit.sv
// Calculation unit: control FSM, result/accumulator and output registers around the shift-add core.
// Define CAL_UNIT_ACC_EN to accumulate products into result instead of replacing it.
module cal_unit
  import cal_pkg::*;
#(
  parameter int unsigned WIDTH = CAL_WIDTH,
  parameter int unsigned IDX_W = CAL_IDX_W
) (
  input  logic clk,
  input  logic rst,
  cal_if.slave bus
);

  localparam int unsigned RES_W = result_w(WIDTH, IDX_W);

  cal_state_e           state;
  cal_state_e           state_next;
  logic                 load;
  logic                 clear;
  logic                 step;
  logic                 last_c;
  logic [2*WIDTH-1:0]   product;
  logic [IDX_W-1:0]     idx_q;
  logic                 finish_q;
  logic                 busy_q;
  logic [RES_W-1:0]     result_q;
  logic [IDX_W-1:0]     result_index_q;

  cal_shift_add #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .clear   (clear),
    .step    (step),
    .a_in    (bus.data_in[2*WIDTH-1:WIDTH]),
    .b_in    (bus.data_in[WIDTH-1:0]),
    .last_c  (last_c),
    .product (product)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Strobes outside IDLE fall through untouched, so a stray write_reg is simply dropped.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    clear      = 1'b0;
    step       = 1'b0;
    unique case (state)
      ST_IDLE: if (bus.write_reg) begin
        load       = 1'b1;
        state_next = ST_LOAD;
      end
      ST_LOAD: begin
        clear      = 1'b1;
        state_next = ST_BUSY;
      end
      ST_BUSY: begin
        step = 1'b1;
        if (last_c) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)       idx_q <= '0;
    else if (load) idx_q <= bus.index;
  end

  // busy follows the next state so the registered flag lines up with LOAD/BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      finish_q       <= 1'b0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_index_q <= '0;
    end else begin
      finish_q <= (state == ST_DONE);
      busy_q   <= (state_next == ST_LOAD) || (state_next == ST_BUSY);
      if (state == ST_DONE) begin
`ifdef CAL_UNIT_ACC_EN
        result_q <= result_q + RES_W'(product);
`else
        result_q <= RES_W'(product);
`endif
        result_index_q <= idx_q;
      end
    end
  end

  assign bus.cal_finish   = finish_q;
  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_index = result_index_q;

endmodule

// File: tb/tb_cal_unit.sv
// Directed bench for cal_unit; expectations follow CAL_UNIT_ACC_EN when it is defined.
module tb_cal_unit;
  import cal_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned IW = 8;
  localparam int unsigned RW = 2 * W + IW;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   pulse_cnt;

  cal_if #(.WIDTH(W), .IDX_W(IW)) bus ();

  cal_unit #(.WIDTH(W), .IDX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.cal_finish === 1'b1) pulse_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one strobe; returns half a cycle after the sampling edge.
  task automatic strobe(input logic [W-1:0] a, input logic [W-1:0] b, input logic [IW-1:0] idx);
    @(negedge clk);
    bus.write_reg = 1'b1;
    bus.data_in   = {a, b};
    bus.index     = idx;
    @(negedge clk);
    bus.write_reg = 1'b0;
  endtask

  task automatic wait_finish(output int lat, output int bcyc);
    lat  = 0;
    bcyc = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.busy === 1'b1) bcyc++;
      if (bus.cal_finish === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  int             lat;
  int             bcyc;
  int             p0;
  logic [RW-1:0]  exp_sum;
  logic [RW-1:0]  exp_res;
  logic [RW-1:0]  prod;

  initial begin
    vectors        = 0;
    miscompares    = 0;
    pulse_cnt      = 0;
    rst            = 1'b1;
    bus.write_reg  = 1'b0;
    bus.data_in    = '0;
    bus.index      = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_finish", 64'(bus.cal_finish), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_index", 64'(bus.result_index), 64'd0);

    // 3*5 at index 0
    strobe(16'd3, 16'd5, 8'd0);
    check("op1_busy_load", 64'(bus.busy), 64'd1);
    wait_finish(lat, bcyc);
    check("op1_latency", 64'(lat), 64'd18);
    check("op1_busy_cycles", 64'(bcyc), 64'd16);
    check("op1_result", 64'(bus.result), 64'd15);
    check("op1_index", 64'(bus.result_index), 64'd0);
    @(posedge clk); #1;
    check("op1_pulse_width", 64'(bus.cal_finish), 64'd0);
    check("op1_busy_after", 64'(bus.busy), 64'd0);
    check("op1_result_hold", 64'(bus.result), 64'd15);

    // 2*7 at index 1
    strobe(16'd2, 16'd7, 8'd1);
    wait_finish(lat, bcyc);
    check("op2_latency", 64'(lat), 64'd18);
`ifdef CAL_UNIT_ACC_EN
    check("op2_result", 64'(bus.result), 64'd29);
`else
    check("op2_result", 64'(bus.result), 64'd14);
`endif
    check("op2_index", 64'(bus.result_index), 64'd1);

    // Full-scale operands
    do_reset();
    check("rst2_result", 64'(bus.result), 64'd0);
    strobe(16'hFFFF, 16'hFFFF, 8'd2);
    wait_finish(lat, bcyc);
    check("max_latency", 64'(lat), 64'd18);
    check("max_result", 64'(bus.result), 64'hFFFE_0001);
    check("max_index", 64'(bus.result_index), 64'd2);

    // Zero operand still takes full latency
    strobe(16'd0, 16'h1234, 8'd3);
    wait_finish(lat, bcyc);
    check("zero_latency", 64'(lat), 64'd18);
`ifdef CAL_UNIT_ACC_EN
    check("zero_result", 64'(bus.result), 64'hFFFE_0001);
`else
    check("zero_result", 64'(bus.result), 64'd0);
`endif
    check("zero_index", 64'(bus.result_index), 64'd3);

    // Strobe five cycles into an operation is ignored
    do_reset();
    p0 = pulse_cnt;
    strobe(16'd3, 16'd5, 8'd4);
    repeat (4) @(negedge clk);
    bus.write_reg = 1'b1;
    bus.data_in   = 32'h0009_0009;
    bus.index     = 8'd9;
    @(negedge clk);
    bus.write_reg = 1'b0;
    wait_finish(lat, bcyc);
    check("ign_latency", 64'(lat), 64'd13);
    check("ign_busy_cycles", 64'(bcyc), 64'd11);
    check("ign_result", 64'(bus.result), 64'd15);
    check("ign_index", 64'(bus.result_index), 64'd4);
    repeat (25) @(posedge clk);
    #1;
    check("ign_pulses", 64'(pulse_cnt - p0), 64'd1);
    check("ign_busy_idle", 64'(bus.busy), 64'd0);

    // Reset at cycle 10 aborts without a pulse
    p0 = pulse_cnt;
    strobe(16'd3, 16'd5, 8'd5);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("abort_pulses", 64'(pulse_cnt - p0), 64'd0);
    check("abort_result", 64'(bus.result), 64'd0);
    check("abort_index", 64'(bus.result_index), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    strobe(16'd4, 16'd4, 8'd6);
    wait_finish(lat, bcyc);
    check("after_abort_latency", 64'(lat), 64'd18);
    check("after_abort_result", 64'(bus.result), 64'd16);
    check("after_abort_index", 64'(bus.result_index), 64'd6);

    // Back-to-back controller handshake over all 256 indices
    do_reset();
    exp_sum = '0;
    p0      = pulse_cnt;
    for (int i = 0; i < 256; i++) begin
      if (i != 0) @(negedge clk);
      strobe(W'(i + 1), 16'd3, IW'(i));
      wait_finish(lat, bcyc);
      prod = RW'((i + 1) * 3);
`ifdef CAL_UNIT_ACC_EN
      exp_sum = exp_sum + prod;
      exp_res = exp_sum;
`else
      exp_res = prod;
`endif
      check($sformatf("b2b_latency_%0d", i), 64'(lat), 64'd18);
      check($sformatf("b2b_result_%0d", i), 64'(bus.result), 64'(exp_res));
      check($sformatf("b2b_index_%0d", i), 64'(bus.result_index), 64'(i));
    end
    repeat (3) @(posedge clk);
    #1;
    check("b2b_pulses", 64'(pulse_cnt - p0), 64'd256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cal_unit.md
CAL_UNIT -- requirements
Module: cal_unit

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits.
REQ-002 Parameter IDX_W, default 8, width of the index tag.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, driven by the controller during its init state.
REQ-005 write_reg  input  1  one-cycle load strobe; operands on data_in and index are valid in the same cycle.
REQ-006 index  input  IDX_W  element number supplied by the controller's counter.
REQ-007 data_in  input  2*WIDTH  operand word: A = data_in[2*WIDTH-1:WIDTH], B = data_in[WIDTH-1:0], both unsigned.
REQ-008 cal_finish  output  1  registered one-cycle pulse marking a valid result.
REQ-009 result  output  2*WIDTH+IDX_W  product, or running sum when accumulation is compiled in.
REQ-010 result_index  output  IDX_W  index latched with the operands that produced result.
REQ-011 busy  output  1  high while states LOAD or BUSY are active.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, BUSY and DONE, with encoding from cal_pkg.
REQ-013 IDLE: write_reg=1 latches A, B and index, then goes to LOAD; write_reg=0 stays in IDLE.
REQ-014 LOAD: clears the partial product and the bit counter, then goes to BUSY unconditionally.
REQ-015 BUSY: each cycle, if the current LSB of B is 1, adds A shifted left by the counter value into the partial product; then shifts B right and increments the counter.
REQ-016 BUSY: after exactly WIDTH iterations, goes to DONE.
REQ-017 DONE: drives cal_finish=1 for exactly one cycle, updates result and result_index, then goes to IDLE.
REQ-018 Latency: write_reg sampled at edge T produces cal_finish high in the cycle after edge T+WIDTH+2 (18 cycles for WIDTH=16).
REQ-019 The partial product SHALL be 2*WIDTH bits with no overflow possible; it is zero-extended into result.
REQ-020 write_reg in LOAD, BUSY or DONE SHALL be ignored: no relatch, no restart, no error.
REQ-021 result and result_index SHALL hold their values from DONE until the next DONE.
REQ-022 A zero operand SHALL still take the full latency and yield product 0.

Reset
REQ-023 rst=1 SHALL force IDLE, and clear cal_finish, busy, result, result_index, the accumulator and all operand registers, by the next edge.
REQ-024 rst asserted mid-operation SHALL abort it with no cal_finish pulse; rst has priority over write_reg in the same cycle.

Configuration
REQ-025 With macro CAL_UNIT_ACC_EN defined, DONE SHALL set result = previous result + product, wrapping modulo 2^(2*WIDTH+IDX_W); only rst clears the sum.
REQ-026 Without CAL_UNIT_ACC_EN, DONE SHALL set result = product, and no accumulator register is synthesised.

Structure
REQ-027 Package cal_pkg SHALL hold the state typedef/encoding, the default WIDTH and IDX_W constants, and the derived result width.
REQ-028 The shift-add core (operand registers, partial product, bit counter) SHALL be a single sub-module cal_shift_add; cal_unit holds the FSM, the accumulator and the output registers.

Verification
REQ-029 rst, then write_reg with data_in=0x0003_0005 and index=0 -> cal_finish pulse 18 cycles later, result=15, result_index=0, busy low afterwards.
REQ-030 data_in=0xFFFF_FFFF -> result=0xFFFE0001 (no accumulation), or that value added to the prior sum (with CAL_UNIT_ACC_EN).
REQ-031 With CAL_UNIT_ACC_EN: 3*5 at index 0, then 2*7 at index 1 -> results 15 then 29, result_index 1; without the macro -> 15 then 14.
REQ-032 write_reg pulsed with 0x0009_0009 five cycles into a 3*5 operation -> one cal_finish only, result=15, busy timing unchanged.
REQ-033 rst asserted at cycle 10 of a 3*5 operation -> no cal_finish, result=0; a following 4*4 yields 16 at the normal latency.
REQ-034 Back-to-back handshake mimicking the controller (write_reg two cycles after each cal_finish, 256 indices) -> 256 pulses, result_index 0..255, no lost or duplicated strobes.
